// File: rtl/tlp_symbol_framer.sv
// tlp_symbol_framer
// Transmit-side framer between the data link layer and the lane controller.
// 32-bit MAC words (valid/ready, end-of-packet flag) are buffered in a small
// FIFO. Each packet is sent as a byte stream wrapped as STP ... payload ... END.
// A packet that cannot be sent contiguously is closed with EDB instead. This
// happens on a FIFO underrun or when the packet exceeds MAX_PKT_WORDS.
//
// Ports
//   clk_i                   single clock
//   rst_ni                  asynchronous active-low reset
//   mac_data_frame_i        payload word, byte 0 = bits[7:0] sent first
//   mac_data_frame_valid_i  word valid
//   mac_data_frame_last_i   word is last of its packet
//   mac_data_frame_ready_o  FIFO can accept a word
//   sym_data_o              symbol byte
//   sym_is_k_o              symbol is a K-code
//   sym_valid_o             symbol valid
//   sym_ready_i             downstream accepts symbol
//   frame_active_o          high from STP output through END/EDB acceptance
//   nullify_o               one-cycle pulse after EDB is accepted
//
// state  | meaning
// IDLE   | no symbol presented, waiting for a word in the FIFO
// STP    | STP K-code presented
// DATA   | payload byte idx of the held word presented
// END    | END K-code presented
// EDB    | EDB K-code presented (packet nullified)
// DRAIN  | discarding the rest of a nullified packet up to its last word
module tlp_symbol_framer #(
   parameter int MAC_FRAME_WIDTH = 32,
   parameter int FIFO_DEPTH      = 4,
   parameter int MAX_PKT_WORDS   = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [MAC_FRAME_WIDTH-1:0] mac_data_frame_i,
   input  logic                       mac_data_frame_valid_i,
   input  logic                       mac_data_frame_last_i,
   output logic                       mac_data_frame_ready_o,
   output logic [7:0]                 sym_data_o,
   output logic                       sym_is_k_o,
   output logic                       sym_valid_o,
   input  logic                       sym_ready_i,
   output logic                       frame_active_o,
   output logic                       nullify_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WC_W  = $clog2(MAX_PKT_WORDS + 1);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [WC_W-1:0]  MAX_WC   = WC_W'(MAX_PKT_WORDS);

   localparam logic [7:0] K_STP = 8'hFB;
   localparam logic [7:0] K_END = 8'hFD;
   localparam logic [7:0] K_EDB = 8'hFE;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_STP   = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_END   = 3'd3;
   localparam logic [2:0] S_EDB   = 3'd4;
   localparam logic [2:0] S_DRAIN = 3'd5;

   // input FIFO, entries are {last, data}
   logic [MAC_FRAME_WIDTH:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]           wr_ptr, rd_ptr;
   logic [CNT_W-1:0]           count;
   logic                       push, pop, fifo_empty;
   logic [MAC_FRAME_WIDTH:0]   head;
   logic [MAC_FRAME_WIDTH-1:0] head_data;
   logic                       head_last;

   assign mac_data_frame_ready_o = (count != FULL_CNT);
   assign push       = mac_data_frame_valid_i && mac_data_frame_ready_o;
   assign fifo_empty = (count == '0);
   assign head       = mem[rd_ptr];
   assign head_data  = head[MAC_FRAME_WIDTH-1:0];
   assign head_last  = head[MAC_FRAME_WIDTH];

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= {mac_data_frame_last_i, mac_data_frame_i};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // framer FSM
   logic [2:0]                 state_q, state_d;
   logic [1:0]                 idx_q, idx_d;
   logic [WC_W-1:0]            wcnt_q, wcnt_d;
   logic [MAC_FRAME_WIDTH-1:0] word_q, word_d;
   logic                       last_q, last_d;
   logic [7:0]                 data_d;
   logic                       k_d, valid_d, active_d, nullify_d;
   logic                       advance, fetch, start, to_edb;

   always_comb begin
      advance   = !sym_valid_o || sym_ready_i;
      state_d   = state_q;
      idx_d     = idx_q;
      wcnt_d    = wcnt_q;
      word_d    = word_q;
      last_d    = last_q;
      data_d    = sym_data_o;
      k_d       = sym_is_k_o;
      valid_d   = sym_valid_o;
      active_d  = frame_active_o;
      nullify_d = 1'b0;
      pop       = 1'b0;
      fetch     = 1'b0;
      start     = 1'b0;
      to_edb    = 1'b0;

      case (state_q)
         S_IDLE:  start = !fifo_empty;
         S_STP:   fetch = advance;
         S_DATA: begin
            if (advance) begin
               if (idx_q != 2'd3) begin
                  idx_d  = idx_q + 2'd1;
                  data_d = word_q[{idx_d, 3'b000} +: 8];
               end else if (last_q) begin
                  state_d = S_END;
                  data_d  = K_END;
                  k_d     = 1'b1;
               end else if (wcnt_q == MAX_WC) begin
                  to_edb = 1'b1;
               end else begin
                  fetch = 1'b1;
               end
            end
         end
         S_END: begin
            if (advance) begin
               idx_d  = '0;
               wcnt_d = '0;
               if (!fifo_empty) begin
                  start = 1'b1;
               end else begin
                  state_d  = S_IDLE;
                  valid_d  = 1'b0;
                  active_d = 1'b0;
               end
            end
         end
         S_EDB: begin
            if (advance) begin
               nullify_d = 1'b1;
               valid_d   = 1'b0;
               active_d  = 1'b0;
               idx_d     = '0;
               wcnt_d    = '0;
               state_d   = last_q ? S_IDLE : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (head_last) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // next payload word is needed right at the accept so bytes stay back-to-back
      if (fetch) begin
         if (fifo_empty) begin
            to_edb = 1'b1;
         end else begin
            pop     = 1'b1;
            word_d  = head_data;
            last_d  = head_last;
            data_d  = head_data[7:0];
            k_d     = 1'b0;
            idx_d   = '0;
            wcnt_d  = wcnt_q + WC_W'(1);
            state_d = S_DATA;
         end
      end

      if (to_edb) begin
         state_d = S_EDB;
         data_d  = K_EDB;
         k_d     = 1'b1;
      end

      if (start) begin
         state_d  = S_STP;
         data_d   = K_STP;
         k_d      = 1'b1;
         valid_d  = 1'b1;
         active_d = 1'b1;
         idx_d    = '0;
         wcnt_d   = '0;
         last_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= S_IDLE;
         idx_q          <= '0;
         wcnt_q         <= '0;
         word_q         <= '0;
         last_q         <= 1'b0;
         sym_data_o     <= 8'h00;
         sym_is_k_o     <= 1'b0;
         sym_valid_o    <= 1'b0;
         frame_active_o <= 1'b0;
         nullify_o      <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         wcnt_q         <= wcnt_d;
         word_q         <= word_d;
         last_q         <= last_d;
         sym_data_o     <= data_d;
         sym_is_k_o     <= k_d;
         sym_valid_o    <= valid_d;
         frame_active_o <= active_d;
         nullify_o      <= nullify_d;
      end
   end

endmodule

// File: tb/tb_tlp_symbol_framer.sv
module tb_tlp_symbol_framer;
   localparam int MAX = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] din = '0;
   logic        dvalid = 1'b0, dlast = 1'b0, dready;
   logic [7:0]  sym_data;
   logic        sym_k, sym_valid, sym_ready = 1'b0, frame_active, nullify;

   always #5 clk = ~clk;

   tlp_symbol_framer #(.MAC_FRAME_WIDTH(32), .FIFO_DEPTH(4), .MAX_PKT_WORDS(MAX)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .mac_data_frame_i(din), .mac_data_frame_valid_i(dvalid),
      .mac_data_frame_last_i(dlast), .mac_data_frame_ready_o(dready),
      .sym_data_o(sym_data), .sym_is_k_o(sym_k), .sym_valid_o(sym_valid),
      .sym_ready_i(sym_ready), .frame_active_o(frame_active), .nullify_o(nullify));

   int errors = 0, checks = 0;
   int cyc = 0;
   logic [8:0]  exp_q[$];
   int exp_null = 0, null_seen = 0;
   logic [31:0] pkt[8];
   int rdy_mode = 0;
   int pushes_done = 0, push_cyc = 0, stp_cyc = -1, active_cyc = 0;
   int fb_gap = -1, last_fd_cyc = -1000;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // reference model: what the symbol stream for one packet must look like
   task automatic expect_pkt(input int n);
      int nw;
      nw = (n > MAX) ? MAX : n;
      exp_q.push_back({1'b1, 8'hFB});
      for (int i = 0; i < nw; i++)
         for (int b = 0; b < 4; b++)
            exp_q.push_back({1'b0, pkt[i][8*b +: 8]});
      if (n > MAX) begin
         exp_q.push_back({1'b1, 8'hFE});
         exp_null++;
      end else begin
         exp_q.push_back({1'b1, 8'hFD});
      end
   endtask

   // downstream ready generator
   initial begin
      int ph = 0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0: sym_ready = 1'b1;
            1: sym_ready = 1'($urandom_range(0, 1));
            2: begin sym_ready = (ph == 0 || ph == 3); ph = (ph + 1) % 4; end
            default: sym_ready = 1'b0;
         endcase
      end
   end

   // monitor / scoreboard
   initial begin
      logic pv, pr, pn;
      logic [8:0] pd, s;
      pv = 0; pr = 0; pn = 0; pd = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pv = 0; pr = 0; pn = 0;
         end else begin
            s = {sym_k, sym_data};
            if (pv && !pr) chk("stall_hold", {sym_valid, s}, {1'b1, pd});
            if (sym_valid) begin
               chk("active_with_sym", frame_active, 1);
               if (stp_cyc < 0 && s == {1'b1, 8'hFB}) stp_cyc = cyc;
            end
            if (sym_valid && sym_ready) begin
               if (s == {1'b1, 8'hFB}) fb_gap = cyc - last_fd_cyc;
               if (s == {1'b1, 8'hFD}) last_fd_cyc = cyc;
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_sym: got %0h expected none", s);
               end else begin
                  chk("sym", s, exp_q.pop_front());
               end
            end
            if (frame_active) active_cyc++;
            if (nullify) begin
               null_seen++;
               chk("nullify_width", {pn, nullify}, 2'b01);
            end
            pv = sym_valid; pr = sym_ready; pd = s; pn = nullify;
         end
      end
   end

   task automatic push_word(input logic [31:0] w, input logic last, input bit first);
      int t = 0;
      din = w; dlast = last; dvalid = 1'b1;
      @(negedge clk);
      while (!dready && t < 500) begin @(negedge clk); t++; end
      if (t >= 500) begin
         checks++; errors++;
         $display("FAIL push_timeout: ready stuck low, expected high");
      end
      if (first) push_cyc = cyc;
      @(posedge clk); #1;
      pushes_done++;
      dvalid = 1'b0; dlast = 1'b0;
   endtask

   task automatic send_pkt(input int n);
      expect_pkt(n);
      for (int i = 0; i < n; i++) push_word(pkt[i], (i == n - 1), (i == 0));
   endtask

   task automatic rand_pkt(input int n);
      for (int i = 0; i < n; i++) pkt[i] = $urandom;
   endtask

   task automatic wait_done(input string name);
      int t = 0;
      while ((exp_q.size() != 0 || frame_active) && t < 3000) begin @(negedge clk); t++; end
      if (t >= 3000) begin
         checks++; errors++;
         $display("FAIL %s_timeout: %0d symbols outstanding, expected 0", name, exp_q.size());
      end
      repeat (10) @(negedge clk);
      chk({name, "_nullify"}, null_seen, exp_null);
      @(posedge clk); #1;
   endtask

   initial begin
      int t;
      #1;
      chk("rst_valid", sym_valid, 0);
      chk("rst_data", {sym_k, sym_data}, 0);
      chk("rst_active", frame_active, 0);
      chk("rst_nullify", nullify, 0);
      chk("rst_ready", dready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single packet, latency and frame_active span
      rdy_mode = 0;
      pkt[0] = 32'h44332211; pkt[1] = 32'h88776655;
      stp_cyc = -1; active_cyc = 0;
      send_pkt(2);
      wait_done("single");
      chk("stp_latency", stp_cyc - push_cyc, 2);
      chk("active_span", active_cyc, 10);

      // same packet under backpressure
      rdy_mode = 2;
      send_pkt(2);
      wait_done("backpressure");

      // FIFO full while downstream stalled
      rdy_mode = 3;
      rand_pkt(5);
      pushes_done = 0;
      fork
         send_pkt(5);
         begin
            repeat (12) @(negedge clk);
            chk("full_pushes", pushes_done, 4);
            chk("full_ready", dready, 0);
            rdy_mode = 0;
         end
      join
      chk("full_all_pushed", pushes_done, 5);
      wait_done("fifo_full");

      // underrun: one word then input starves
      rdy_mode = 0;
      rand_pkt(1);
      exp_q.push_back({1'b1, 8'hFB});
      for (int b = 0; b < 4; b++) exp_q.push_back({1'b0, pkt[0][8*b +: 8]});
      exp_q.push_back({1'b1, 8'hFE});
      exp_null++;
      push_word(pkt[0], 1'b0, 1'b1);
      repeat (8) begin @(posedge clk); #1; end
      push_word($urandom, 1'b0, 1'b0);
      push_word($urandom, 1'b1, 1'b0);
      rand_pkt(2);
      send_pkt(2);
      wait_done("underrun");

      // over-length packet
      rand_pkt(3);
      send_pkt(3);
      wait_done("overlength");

      // back-to-back single-word packets
      fb_gap = -1;
      rand_pkt(1); send_pkt(1);
      rand_pkt(1); send_pkt(1);
      wait_done("b2b");
      chk("b2b_gap", fb_gap, 1);

      // reset in the middle of a packet
      rand_pkt(2);
      send_pkt(2);
      t = 0;
      while (exp_q.size() > 6 && t < 200) begin @(negedge clk); t++; end
      chk("midrst_reached_data", (exp_q.size() <= 6), 1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", sym_valid, 0);
      chk("midrst_ready", dready, 1);
      chk("midrst_active", frame_active, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      @(posedge clk); #1;
      rand_pkt(2);
      send_pkt(2);
      wait_done("after_reset");

      // randomized traffic
      rdy_mode = 1;
      for (int p = 0; p < 40; p++) begin
         int n;
         n = $urandom_range(1, 3);
         rand_pkt(n);
         send_pkt(n);
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      wait_done("random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog");
   end
endmodule
